// File: rtl/regfile_wport_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_wport_arbiter_pkg: shared register-file constants and helpers
// Rev 1.0
// ----------------------------------------------------------------------------
package regfile_wport_arbiter_pkg;

    localparam int RegBus     = 32;
    localparam int RegNum     = 32;
    localparam int RegNumLog2 = 5;
    localparam int RegAddrBus = RegNumLog2;

    localparam logic              WriteEnable  = 1'b1;
    localparam logic              WriteDisable = 1'b0;
    localparam logic [RegBus-1:0] ZeroWord     = '0;

    localparam logic RstActiveLow = 1'b0;
    localparam int   NumWbReq     = 3;

    // Single conditional subtract; callers guarantee idx < 2*n.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wport_arbiter_rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter: one-hot round-robin grant with a rotating priority pointer
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_arbiter
    import regfile_wport_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NumWbReq
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic                       grant_valid_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    int               cand;
    int               next_idx;

    // Scan from farthest to nearest so the candidate closest to ptr wins last.
    always_comb begin
        grant_o       = '0;
        grant_valid_o = 1'b0;
        grant_idx_o   = ptr_q;
        cand          = 0;
        next_idx      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = rr_wrap(int'(ptr_q) + k, NUM_REQ);
            if (req_i[cand[PTR_W-1:0]]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = cand[PTR_W-1:0];
            end
        end
        if (grant_valid_o) begin
            grant_o[grant_idx_o] = 1'b1;
        end
        next_idx = rr_wrap(int'(grant_idx_o) + 1, NUM_REQ);
        ptr_d    = grant_valid_o ? next_idx[PTR_W-1:0] : ptr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstActiveLow) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wport_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// regfile_wport_arbiter: round-robin share of the regfile write port plus
// a per-register busy scoreboard. Rev 1.0
// ----------------------------------------------------------------------------
module regfile_wport_arbiter
    import regfile_wport_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NumWbReq,
    parameter int REG_NUM = RegNum,
    parameter int ADDR_W  = RegAddrBus,
    parameter int DATA_W  = RegBus
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_waddr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      rsv_valid,
    input  logic [ADDR_W-1:0]         rsv_addr,
    output logic [REG_NUM-1:0]        busy_vec,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] gnt;
    logic               gnt_valid;
    logic [PTR_W-1:0]   gnt_idx;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    logic               we_q,    we_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [REG_NUM-1:0] busy_q,  busy_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req_valid),
        .grant_o       (gnt),
        .grant_valid_o (gnt_valid),
        .grant_idx_o   (gnt_idx)
    );

    assign req_ready = (rst == RstActiveLow) ? '0 : gnt;
    assign sel_addr  = req_waddr[gnt_idx*ADDR_W +: ADDR_W];
    assign sel_data  = req_wdata[gnt_idx*DATA_W +: DATA_W];

    // A grant to r0 is consumed but never produces a regfile write.
    always_comb begin
        we_d    = WriteDisable;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (gnt_valid) begin
            we_d    = (sel_addr != '0) ? WriteEnable : WriteDisable;
            waddr_d = sel_addr;
            wdata_d = sel_data;
        end
    end

    // Reservation is applied after retirement so a same-cycle set wins.
    always_comb begin
        busy_d = busy_q;
        if (we_q) begin
            busy_d[waddr_q] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != '0)) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstActiveLow) begin
            we_q    <= WriteDisable;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
        end
    end

    assign rf_we    = we_q;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;
    assign busy_vec = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wport_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_regfile_wport_arbiter: vector table, corner sequences and random traffic
// against a cycle-level reference model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_regfile_wport_arbiter;

    localparam int NREQ = 3;

    logic             clk;
    logic             rst;
    logic [NREQ-1:0]  req_valid;
    logic [NREQ*5-1:0]  req_waddr;
    logic [NREQ*32-1:0] req_wdata;
    logic [NREQ-1:0]  req_ready;
    logic             rsv_valid;
    logic [4:0]       rsv_addr;
    logic [31:0]      busy_vec;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [31:0]      rf_wdata;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int        m_ptr;
    bit        m_we;
    bit [4:0]  m_waddr;
    bit [31:0] m_wdata;
    bit [31:0] m_busy;

    typedef struct {
        bit [2:0]  v;
        bit [4:0]  a0, a1, a2;
        bit [31:0] d0, d1, d2;
        bit [2:0]  e_rdy;
        bit        e_we;
        bit        chk_wd;
        bit [4:0]  e_wa;
        bit [31:0] e_wd;
    } vec_t;

    vec_t tbl [12];

    regfile_wport_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_waddr (req_waddr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .busy_vec  (busy_vec),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int pick(input int p, input bit [2:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic vec_t mk(input bit [2:0] v, input bit [4:0] a0, input bit [4:0] a1,
                                input bit [4:0] a2, input bit [31:0] d0, input bit [31:0] d1,
                                input bit [31:0] d2, input bit [2:0] e_rdy, input bit e_we,
                                input bit chk_wd, input bit [4:0] e_wa, input bit [31:0] e_wd);
        vec_t r;
        r.v = v; r.a0 = a0; r.a1 = a1; r.a2 = a2;
        r.d0 = d0; r.d1 = d1; r.d2 = d2;
        r.e_rdy = e_rdy; r.e_we = e_we; r.chk_wd = chk_wd; r.e_wa = e_wa; r.e_wd = e_wd;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic mreset();
        m_ptr = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_busy = 0;
    endtask

    task automatic setin(input bit [2:0] v, input bit [4:0] a0, input bit [4:0] a1,
                         input bit [4:0] a2, input bit [31:0] d0, input bit [31:0] d1,
                         input bit [31:0] d2, input bit rv, input bit [4:0] ra);
        req_valid = v;
        req_waddr = {a2, a1, a0};
        req_wdata = {d2, d1, d0};
        rsv_valid = rv;
        rsv_addr  = ra;
    endtask

    // Mid-cycle comparison of every output against the model.
    task automatic sample();
        int       g;
        bit [2:0] er;
        @(negedge clk);
        g  = pick(m_ptr, req_valid);
        er = (g < 0 || !rst) ? 3'b000 : 3'(1 << g);
        chk("m_ready", req_ready, er);
        chk("m_we",    rf_we,     m_we);
        chk("m_waddr", rf_waddr,  m_waddr);
        chk("m_wdata", rf_wdata,  m_wdata);
        chk("m_busy",  busy_vec,  m_busy);
    endtask

    task automatic tick();
        int g;
        @(posedge clk);
        if (!rst) begin
            mreset();
        end else begin
            g = pick(m_ptr, req_valid);
            if (m_we) m_busy[m_waddr] = 1'b0;
            if (rsv_valid && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
            if (g >= 0) begin
                m_waddr = req_waddr[g*5 +: 5];
                m_wdata = req_wdata[g*32 +: 32];
                m_we    = (m_waddr != 0);
                m_ptr   = (g + 1) % NREQ;
            end else begin
                m_we = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        tbl[0]  = mk(3'b111, 1, 2, 3, 'h100, 'h200, 'h300, 3'b001, 0, 1, 0, 0);
        tbl[1]  = mk(3'b111, 1, 2, 3, 'h100, 'h200, 'h300, 3'b010, 1, 1, 1, 'h100);
        tbl[2]  = mk(3'b111, 1, 2, 3, 'h100, 'h200, 'h300, 3'b100, 1, 1, 2, 'h200);
        tbl[3]  = mk(3'b111, 1, 2, 3, 'h100, 'h200, 'h300, 3'b001, 1, 1, 3, 'h300);
        tbl[4]  = mk(3'b111, 1, 2, 3, 'h100, 'h200, 'h300, 3'b010, 1, 1, 1, 'h100);
        tbl[5]  = mk(3'b111, 1, 2, 3, 'h100, 'h200, 'h300, 3'b100, 1, 1, 2, 'h200);
        tbl[6]  = mk(3'b110, 1, 2, 3, 'h100, 'h200, 'h300, 3'b010, 1, 1, 3, 'h300);
        tbl[7]  = mk(3'b001, 5, 0, 0, 'hDEADBEEF, 0, 0,    3'b001, 1, 1, 2, 'h200);
        tbl[8]  = mk(3'b000, 0, 0, 0, 0, 0, 0,             3'b000, 1, 1, 5, 'hDEADBEEF);
        tbl[9]  = mk(3'b000, 0, 0, 0, 0, 0, 0,             3'b000, 0, 1, 5, 'hDEADBEEF);
        tbl[10] = mk(3'b010, 0, 0, 0, 0, 'h55, 0,          3'b010, 0, 1, 5, 'hDEADBEEF);
        tbl[11] = mk(3'b000, 0, 0, 0, 0, 0, 0,             3'b000, 0, 0, 0, 0);

        // Reset held with every requester asking
        mreset();
        rst = 1'b0;
        setin(3'b111, 1, 2, 3, 'h100, 'h200, 'h300, 0, 0);
        tick();
        sample();
        chk("rst_ready", req_ready, 0);
        chk("rst_we",    rf_we,     0);
        chk("rst_busy",  busy_vec,  0);
        tick();
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            setin(tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].a2,
                  tbl[i].d0, tbl[i].d1, tbl[i].d2, 0, 0);
            sample();
            chk("tbl_ready", req_ready, tbl[i].e_rdy);
            chk("tbl_we",    rf_we,     tbl[i].e_we);
            if (tbl[i].chk_wd) begin
                chk("tbl_waddr", rf_waddr, tbl[i].e_wa);
                chk("tbl_wdata", rf_wdata, tbl[i].e_wd);
            end
            chk("tbl_busy", busy_vec, 0);
            tick();
        end

        // Scoreboard: reserve, retire, and reserve-while-retiring
        for (int pass = 0; pass < 2; pass++) begin
            setin(0, 0, 0, 0, 0, 0, 0, 1, 7);
            sample(); tick();
            setin(0, 0, 0, 0, 0, 0, 0, 1, 0);
            sample();
            chk("sb_set7", busy_vec[7], 1);
            tick();
            setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
            sample();
            chk("sb_r0_never_busy", busy_vec[0], 0);
            tick();
            setin(3'b001, 7, 0, 0, 'h77, 0, 0, 0, 0);
            sample();
            chk("sb_ready", req_ready, 3'b001);
            tick();
            setin(0, 0, 0, 0, 0, 0, 0, pass[0], 7);
            sample();
            chk("sb_we",     rf_we,       1);
            chk("sb_waddr",  rf_waddr,    7);
            chk("sb_busy_t4", busy_vec[7], 1);
            tick();
            setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
            sample();
            chk("sb_we_off", rf_we, 0);
            chk("sb_busy_t5", busy_vec[7], (pass == 0) ? 1'b0 : 1'b1);
            tick();
        end

        // Asynchronous reset while a write is on the port
        setin(3'b111, 1, 2, 3, 'h11, 'h22, 'h33, 1, 9);
        sample(); tick();
        #2;
        chk("pre_rst_we",   rf_we,       1);
        chk("pre_rst_busy", busy_vec[9], 1);
        rst = 1'b0;
        #1;
        chk("arst_we",    rf_we,     0);
        chk("arst_busy",  busy_vec,  0);
        chk("arst_ready", req_ready, 0);
        mreset();
        sample(); tick();
        chk("hold_ready", req_ready, 0);
        chk("hold_we",    rf_we,     0);
        rst = 1'b1;
        setin(3'b111, 1, 2, 3, 'h11, 'h22, 'h33, 0, 0);
        sample();
        chk("first_gnt", req_ready, 3'b001);
        tick();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            setin(3'($urandom_range(0, 7)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  $urandom, $urandom, $urandom,
                  ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));
            sample();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
